// File: rtl/blockram_arbiter_pkg.sv
// Shared types for the two-requester block RAM arbiter.
// Latency: none, type and helper definitions only.
// Backpressure: not applicable.
package blockram_arb_pkg;

    // Lock ownership of RAM port A.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_t;

    // Requester identifier: 0 or 1.
    typedef logic req_id_t;

    // Which requesters may be granted in a given lock state.
    function automatic logic [1:0] grant_mask(input lock_state_t state);
        logic [1:0] mask;
        case (state)
            LOCKED0: mask = 2'b01;
            LOCKED1: mask = 2'b10;
            default: mask = 2'b11;
        endcase
        return mask;
    endfunction

    // Locked state owned by the given requester.
    function automatic lock_state_t locked_state(input req_id_t id);
        return id ? LOCKED1 : LOCKED0;
    endfunction

endpackage

// File: rtl/blockram_arbiter_rr_arb2.sv
// Two-way round-robin grant: the requester other than 'last' wins a tie.
// Latency: purely combinational.
// Backpressure: masked-off requesters never receive a grant.
module rr_arb2
    import blockram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] eligible;

    // One-hot grant among the eligible requesters, tie broken against 'last'.
    always_comb begin
        grant    = 2'b00;
        eligible = valid & mask;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/blockram_arbiter.sv
// Shares RAM port A between two requesters with round-robin grant and an optional timed lock.
// Latency: request to RAM is combinational; read data returns one cycle after acceptance.
// Backpressure: req_ready per requester, at most one high; the non-owner is held off while locked.
module blockram_arbiter
    import blockram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 32,
    parameter int WRITE_WIDTH  = 8,
    parameter int LOCK_TIMEOUT = 256,
    localparam int NB          = DATA_WIDTH / WRITE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][NB-1:0]         req_we,
    input  logic [1:0]                 req_lock,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       lock_err,
    output logic                       ram_ena,
    output logic [NB-1:0]              ram_we,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_din,
    input  logic [DATA_WIDTH-1:0]      ram_dout
);

    // A zero timeout still needs a one-bit counter so the logic elaborates.
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic [NB-1:0]         we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } ram_cmd_t;

    lock_state_t           state, state_nxt;
    req_id_t               last, last_nxt;
    logic [CNT_W-1:0]      lock_cnt, lock_cnt_nxt;
    logic                  rd_pend;
    req_id_t               rd_id;
    logic [DATA_WIDTH-1:0] rdata_hold;

    logic [1:0]            mask;
    logic [1:0]            grant;
    logic [1:0]            xfer;
    logic                  any_xfer;
    req_id_t               win;
    req_id_t               owner;
    logic                  locked;
    logic                  timeout;
    ram_cmd_t              cmd;

    assign mask = grant_mask(state);

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .last  (last),
        .mask  (mask),
        .grant (grant)
    );

    // Acceptance, winner selection and RAM port A drive; nothing is accepted while reset is held.
    always_comb begin
        req_ready = rst_n ? grant : 2'b00;
        xfer      = req_valid & req_ready;
        any_xfer  = |xfer;
        win       = xfer[1];
        cmd.we    = req_we[win];
        cmd.addr  = req_addr[win];
        cmd.din   = req_wdata[win];
        ram_ena   = any_xfer;
        ram_we    = any_xfer ? cmd.we : '0;
        ram_addr  = cmd.addr;
        ram_din   = cmd.din;
    end

    // Lock owner and timeout detection for the current cycle.
    always_comb begin
        owner    = (state == LOCKED1);
        locked   = (state != UNLOCKED);
        timeout  = locked && (LOCK_TIMEOUT != 0) && (lock_cnt == CNT_LAST);
        lock_err = timeout;
    end

    // Lock state machine, round-robin history and lock timer next-state.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        lock_cnt_nxt = lock_cnt;
        if (any_xfer) begin
            last_nxt = win;
        end
        case (state)
            UNLOCKED: begin
                lock_cnt_nxt = '0;
                if (any_xfer && req_lock[win]) begin
                    state_nxt = locked_state(win);
                end
            end
            LOCKED0, LOCKED1: begin
                if (lock_cnt != CNT_MAX) begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
                if (timeout) begin
                    // An expired lock hands the next tie to the other requester; a
                    // transfer by the owner in this cycle is accepted but cannot re-lock.
                    state_nxt = UNLOCKED;
                    last_nxt  = owner;
                end else if (xfer[owner] && !req_lock[owner]) begin
                    state_nxt = UNLOCKED;
                end else if (!req_valid[owner] && !req_lock[owner]) begin
                    state_nxt = UNLOCKED;
                end
            end
            default: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // State registers; reset releases any lock and restores requester 0 priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Read response tracking; reset drops a response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
            rdata_hold <= '0;
        end else begin
            rd_pend <= any_xfer && (ram_we == '0);
            rd_id   <= win;
            if (rd_pend) begin
                rdata_hold <= ram_dout;
            end
        end
    end

    // Response outputs: RAM data passes straight through in the response cycle, held otherwise.
    always_comb begin
        rsp_valid = 2'b00;
        if (rd_pend) begin
            rsp_valid[rd_id] = 1'b1;
        end
        rsp_rdata = rd_pend ? ram_dout : rdata_hold;
    end

endmodule

// File: tb/tb_blockram_arbiter.sv
// Directed bench for blockram_arbiter with a behavioural RAM and a response scoreboard.
// Latency: expects read responses one cycle after acceptance.
// Backpressure: grant patterns are checked cycle by cycle against hand-derived values.
module tb_blockram_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int NB = 4;

    localparam logic [31:0] D10 = 32'h1010_A5A5;
    localparam logic [31:0] D20 = 32'h2020_5A5A;
    localparam logic [31:0] D05 = 32'h1122_3344;
    localparam logic [31:0] D03 = 32'h0000_3333;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][NB-1:0]   req_we;
    logic [1:0]           req_lock;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][DW-1:0]   req_wdata;
    logic [1:0]           rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 lock_err;
    logic                 ram_ena;
    logic [NB-1:0]        ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_din;
    logic [DW-1:0]        ram_dout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    blockram_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .WRITE_WIDTH  (8),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .lock_err  (lock_err),
        .ram_ena   (ram_ena),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural RAM port A: registered read, byte-lane write, dout unchanged on write.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[13'h10] = D10;
        mem[13'h20] = D20;
        mem[13'h05] = D05;
        mem[13'h03] = D03;
        ram_dout    = '0;
    end

    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_we == '0) begin
                ram_dout <= mem[ram_addr];
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input bit v, input bit lk, input logic [3:0] we,
                           input logic [12:0] a, input logic [31:0] d);
        req_valid[r] = v;
        req_lock[r]  = lk;
        req_we[r]    = we;
        req_addr[r]  = a;
        req_wdata[r] = d;
    endtask

    task automatic push(input logic id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b rdata=%h, expected no response at %0t",
                         rsp_valid, rsp_rdata, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
                chk("rsp_data", rsp_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_lock  = 2'b00;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset values, with requests already valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_lock_err", {31'd0, lock_err}, 32'd0);
        chk("rst_ram_ena", {31'd0, ram_ena}, 32'd0);
        chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        next_cycle();

        // Tie from reset: grants alternate 0,1,0,1.
        set_req(0, 1, 0, 4'h0, 13'h10, 32'h0);
        set_req(1, 1, 0, 4'h0, 13'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            push(i[0], i[0] ? D20 : D10);
            @(negedge clk);
            chk("tie_ready", {30'd0, req_ready}, i[0] ? 32'd2 : 32'd1);
            chk("tie_addr", {19'd0, ram_addr}, i[0] ? 32'h20 : 32'h10);
            next_cycle();
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("idle_ena", {31'd0, ram_ena}, 32'd0);
        chk("idle_we", {28'd0, ram_we}, 32'd0);
        next_cycle();

        // Byte-lane write: lanes 0 and 2 take DD and BB over 11223344.
        set_req(0, 1, 0, 4'b0101, 13'h5, 32'hAABB_CCDD);
        @(negedge clk);
        chk("bw_ready", {30'd0, req_ready}, 32'd1);
        chk("bw_we", {28'd0, ram_we}, 32'h5);
        next_cycle();
        set_req(0, 1, 0, 4'h0, 13'h5, 32'h0);
        push(1'b0, 32'h11BB_33DD);
        @(negedge clk);
        chk("bw_rd_ready", {30'd0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 2'b00;

        // Read then write of the same word: old value first, new value after.
        set_req(0, 1, 0, 4'h0, 13'h3, 32'h0);
        push(1'b0, D03);
        @(negedge clk);
        chk("rw_rd_ready", {30'd0, req_ready}, 32'd1);
        next_cycle();
        set_req(0, 0, 0, 4'h0, 13'h3, 32'h0);
        set_req(1, 1, 0, 4'hF, 13'h3, 32'hCAFE_F00D);
        @(negedge clk);
        chk("rw_wr_ready", {30'd0, req_ready}, 32'd2);
        next_cycle();
        set_req(1, 0, 0, 4'h0, 13'h0, 32'h0);
        set_req(0, 1, 0, 4'h0, 13'h3, 32'h0);
        push(1'b0, 32'hCAFE_F00D);
        @(negedge clk);
        chk("rw_rd2_ready", {30'd0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 2'b00;

        // Lock hold by requester 1 while requester 0 keeps asking (last = 0, so 1 wins).
        set_req(0, 1, 0, 4'h0, 13'h10, 32'h0);
        set_req(1, 1, 1, 4'h0, 13'h20, 32'h0);
        push(1'b1, D20);
        @(negedge clk);
        chk("lk_grant", {30'd0, req_ready}, 32'd2);
        next_cycle();
        set_req(1, 0, 1, 4'h0, 13'h20, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lk_hold_ready", {30'd0, req_ready}, 32'd0);
            chk("lk_hold_err", {31'd0, lock_err}, 32'd0);
            next_cycle();
        end
        set_req(1, 1, 0, 4'hF, 13'h21, 32'h1234_5678);
        @(negedge clk);
        chk("lk_unlock_ready", {30'd0, req_ready}, 32'd2);
        next_cycle();
        set_req(1, 0, 0, 4'h0, 13'h0, 32'h0);
        push(1'b0, D10);
        @(negedge clk);
        chk("lk_after_ready", {30'd0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 2'b00;

        // Lock timeout: requester 0 locks, idles holding the lock; error 8 cycles later.
        set_req(0, 1, 1, 4'h0, 13'h10, 32'h0);
        push(1'b0, D10);
        @(negedge clk);
        chk("to_lock_ready", {30'd0, req_ready}, 32'd1);
        next_cycle();
        set_req(0, 0, 1, 4'h0, 13'h10, 32'h0);
        set_req(1, 1, 0, 4'h0, 13'h20, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("to_err", {31'd0, lock_err}, (k == 8) ? 32'd1 : 32'd0);
            chk("to_ready", {30'd0, req_ready}, 32'd0);
            next_cycle();
        end
        push(1'b1, D20);
        @(negedge clk);
        chk("to_other_ready", {30'd0, req_ready}, 32'd2);
        chk("to_err_gone", {31'd0, lock_err}, 32'd0);
        next_cycle();
        set_req(0, 0, 0, 4'h0, 13'h0, 32'h0);
        set_req(1, 0, 0, 4'h0, 13'h0, 32'h0);

        // Reset right after a locking read: response dropped, lock released, requester 0 wins tie.
        set_req(1, 1, 1, 4'h0, 13'h20, 32'h0);
        @(negedge clk);
        chk("rst_rd_ready", {30'd0, req_ready}, 32'd2);
        next_cycle();
        rst_n = 1'b0;
        set_req(1, 0, 0, 4'h0, 13'h0, 32'h0);
        @(negedge clk);
        chk("rst_drop", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        set_req(0, 1, 0, 4'h0, 13'h10, 32'h0);
        set_req(1, 1, 0, 4'h0, 13'h20, 32'h0);
        push(1'b0, D10);
        @(negedge clk);
        chk("post_rst_tie0", {30'd0, req_ready}, 32'd1);
        next_cycle();
        push(1'b1, D20);
        @(negedge clk);
        chk("post_rst_tie1", {30'd0, req_ready}, 32'd2);
        next_cycle();
        req_valid = 2'b00;

        repeat (3) next_cycle();
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
